pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed per-stage boundary registers (IF/ID … MEM/WB).
- Carries an arbitrary-width payload between two pipeline stages.
- Uses a valid/ready handshake, so upstream and downstream stalls are decoupled.
- A one-entry skid buffer keeps throughput at one transfer per cycle; a synchronous flush inserts bubbles.
- One instance per stage boundary; the payload is packed by the parent (e.g. {pc, wD, wR, rf_we}).

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_entry_reg.sv | 21 ++
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: FSM encodings and default payload field widths.
package pipe_pkg;

    localparam int unsigned STATE_W = 2;

    localparam int unsigned PC_W = 32;
    localparam int unsigned WD_W = 32;
    localparam int unsigned WR_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Enable-loaded payload register with asynchronous active-low reset to RESET_VAL.
module pipe_entry_reg #(
    parameter int unsigned       DATA_W    = 70,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a one-entry skid buffer and synchronous flush.
// Optional PIPE_TRACE_EN adds a trace PC carried in lockstep with the payload and a retire counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = PC_W + WD_W + WR_W + 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_TRACE_EN
    ,
    input  logic [PC_W-1:0]   trace_pc_in,
    output logic [PC_W-1:0]   trace_pc_out,
    output logic [31:0]       retire_cnt
`endif
);

    state_e            state_q;
    state_e            state_d;
    logic              in_fire;
    logic              out_fire;
    logic              main_en;
    logic              skid_en;
    logic              main_from_skid;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    // Handshake decodes come straight from the state register, so no input reaches an output.
    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and register load enables; flush overrides every transfer.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    case ({in_fire, out_fire})
                        2'b11: main_en = 1'b1;
                        2'b10: begin
                            skid_en = 1'b1;
                            state_d = ST_SKID;
                        end
                        2'b01: state_d = ST_EMPTY;
                        default: state_d = ST_FULL;
                    endcase
                end
                ST_SKID: begin
                    if (out_fire) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_entry_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .en        (main_en),
        .d         (main_d),
        .q         (out_data)
    );

    pipe_entry_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .en        (skid_en),
        .d         (in_data),
        .q         (skid_q)
    );

`ifdef PIPE_TRACE_EN
    logic [PC_W-1:0] pc_main_d;
    logic [PC_W-1:0] pc_skid_q;

    assign pc_main_d = main_from_skid ? pc_skid_q : trace_pc_in;

    pipe_entry_reg #(.DATA_W(PC_W), .RESET_VAL('0)) u_pc_main (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .en        (main_en),
        .d         (pc_main_d),
        .q         (trace_pc_out)
    );

    pipe_entry_reg #(.DATA_W(PC_W), .RESET_VAL('0)) u_pc_skid (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .en        (skid_en),
        .d         (trace_pc_in),
        .q         (pc_skid_q)
    );

    // Counts every delivered entry, including one delivered in a flush cycle.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            retire_cnt <= '0;
        end else if (out_fire) begin
            retire_cnt <= retire_cnt + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a two-entry FIFO model.
// Build with PIPE_TRACE_EN defined to also exercise the trace PC and retire counter.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 70;

    logic          cpu_clk;
    logic          cpu_rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   tb_pc;
`ifdef PIPE_TRACE_EN
    logic [31:0]   trace_pc_out;
    logic [31:0]   retire_cnt;
`endif

    int checks;
    int failures;

    // Reference model: a FIFO of at most two entries plus a delivered-entry counter.
    logic [DW-1:0] mq_d[$];
    logic [31:0]   mq_pc[$];
    logic [31:0]   m_retire;

    pipe_stage_reg #(.DATA_W(DW)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_TRACE_EN
        ,
        .trace_pc_in  (tb_pc),
        .trace_pc_out (trace_pc_out),
        .retire_cnt   (retire_cnt)
`endif
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Apply inputs (just after a rising edge) and move to the sampling point.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r,
                         input logic f, input logic [31:0] pc);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        tb_pc     = pc;
        @(negedge cpu_clk);
    endtask

    // Advance one rising edge and update the model from the handshake it predicts.
    task automatic tick();
        bit inf;
        bit outf;
        inf  = in_valid && (mq_d.size() < 2);
        outf = out_ready && (mq_d.size() > 0);
        @(posedge cpu_clk);
        if (outf) m_retire = m_retire + 32'd1;
        if (flush) begin
            mq_d.delete();
            mq_pc.delete();
        end else begin
            if (outf) begin
                void'(mq_d.pop_front());
                void'(mq_pc.pop_front());
            end
            if (inf) begin
                mq_d.push_back(in_data);
                mq_pc.push_back(tb_pc);
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        cpu_rst_n = 1'b0;
        mq_d.delete();
        mq_pc.delete();
        m_retire = '0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; tb_pc = '0;
        cpu_rst_n = 1'b0;
        mq_d.delete(); mq_pc.delete(); m_retire = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
`ifdef PIPE_TRACE_EN
        checks++;
        if (retire_cnt !== 32'd0) begin failures++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt); end
`endif
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, '0);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_after_reset valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        logic [DW-1:0] exp_d;
        for (int k = 1; k <= 6; k++) begin
            drive(k <= 4, DW'(k), 1'b1, 1'b0, 32'(k));
            exp_d = DW'(k - 1);
            if (k >= 2 && k <= 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d) begin
                    failures++;
                    $display("FAIL stream_beat%0d valid=%b data=%h exp valid=1 data=%h", k - 1, out_valid, out_data, exp_d);
                end
            end
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready got=%b exp=1", in_ready); end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, DW'(8'h11), 1'b0, 1'b0, 32'h11);
        tick();
        drive(1'b1, DW'(8'h22), 1'b0, 1'b0, 32'h22);
        checks++;
        if (in_ready !== 1'b1 || out_data !== DW'(8'h11)) begin
            failures++; $display("FAIL bp_after_a ready=%b data=%h exp ready=1 data=11", in_ready, out_data);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, DW'(8'h33), 1'b0, 1'b0, 32'h33);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== DW'(8'h11)) begin
                failures++;
                $display("FAIL bp_hold%0d ready=%b valid=%b data=%h exp ready=0 valid=1 data=11", i, in_ready, out_valid, out_data);
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== DW'(8'h22)) begin
            failures++;
            $display("FAIL bp_second ready=%b valid=%b data=%h exp ready=1 valid=1 data=22", in_ready, out_valid, out_data);
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush_skid();
        drive(1'b1, DW'(8'hA1), 1'b0, 1'b0, 32'hA1);
        tick();
        drive(1'b1, DW'(8'hB2), 1'b0, 1'b0, 32'hB2);
        tick();
        drive(1'b1, DW'(8'hC3), 1'b0, 1'b1, 32'hC3);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, '0);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL flush_skid%0d valid=%b ready=%b exp valid=0 ready=1", i, out_valid, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_flush_concurrent();
        drive(1'b1, DW'(8'hAA), 1'b0, 1'b0, 32'hAA);
        tick();
        drive(1'b1, DW'(8'hDD), 1'b1, 1'b1, 32'hDD);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== DW'(8'hAA)) begin
            failures++;
            $display("FAIL flush_conc_pre valid=%b ready=%b data=%h exp valid=1 ready=1 data=aa", out_valid, in_ready, out_data);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, '0);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL flush_conc%0d valid=%b ready=%b exp valid=0 ready=1", i, out_valid, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic          v, r, f;
        logic [DW-1:0] d;
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 2) != 0);
            f = 1'($urandom_range(0, 19) == 0);
            d = {$urandom(), $urandom(), 6'($urandom())};
            drive(v, d, r, f, $urandom());
            checks++;
            if (out_valid !== (mq_d.size() != 0) || in_ready !== (mq_d.size() < 2)) begin
                failures++;
                $display("FAIL rand_hs cyc=%0d valid=%b ready=%b exp occupancy=%0d", i, out_valid, in_ready, mq_d.size());
            end
            if (mq_d.size() != 0) begin
                checks++;
                if (out_data !== mq_d[0]) begin
                    failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, out_data, mq_d[0]);
                end
`ifdef PIPE_TRACE_EN
                checks++;
                if (trace_pc_out !== mq_pc[0]) begin
                    failures++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, trace_pc_out, mq_pc[0]);
                end
`endif
            end
`ifdef PIPE_TRACE_EN
            checks++;
            if (retire_cnt !== m_retire) begin
                failures++; $display("FAIL rand_retire cyc=%0d got=%0d exp=%0d", i, retire_cnt, m_retire);
            end
`endif
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, DW'(8'h5A), 1'b0, 1'b0, 32'h5A);
        tick();
        drive(1'b1, DW'(8'h6B), 1'b0, 1'b0, 32'h6B);
        tick();
        #2;
        cpu_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_mid valid=%b ready=%b data=%h exp valid=0 ready=1 data=0", out_valid, in_ready, out_data);
        end
        apply_reset();
    endtask

`ifdef PIPE_TRACE_EN
    task automatic test_trace();
        int            sent;
        int            cyc;
        logic [DW-1:0] d;
        apply_reset();
        sent = 0;
        cyc  = 0;
        while ((sent < 5 || mq_d.size() != 0) && cyc < 30) begin
            d = {$urandom(), $urandom(), 6'($urandom())};
            drive(sent < 5, d, cyc != 2, 1'b0, 32'h1000 + 32'(4 * sent));
            if (mq_d.size() != 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== mq_d[0] || trace_pc_out !== mq_pc[0]) begin
                    failures++;
                    $display("FAIL trace_beat cyc=%0d valid=%b data=%h pc=%h exp data=%h pc=%h",
                             cyc, out_valid, out_data, trace_pc_out, mq_d[0], mq_pc[0]);
                end
            end
            if (sent < 5 && mq_d.size() < 2) sent++;
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 30) begin failures++; $display("FAIL trace_timeout cycles=%0d limit=30", cyc); end
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (retire_cnt !== 32'd5) begin failures++; $display("FAIL trace_retire got=%0d exp=5", retire_cnt); end
        tick();
        drive(1'b1, DW'(8'h77), 1'b1, 1'b0, 32'h2000);
        tick();
        #2;
        cpu_rst_n = 1'b0;
        #1;
        checks++;
        if (retire_cnt !== 32'd0 || trace_pc_out !== 32'd0) begin
            failures++; $display("FAIL trace_reset retire=%0d pc=%h exp retire=0 pc=0", retire_cnt, trace_pc_out);
        end
        apply_reset();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_streaming();
        tick();
        test_backpressure();
        tick();
        test_flush_skid();
        test_flush_concurrent();
        test_random();
        test_reset_mid();
`ifdef PIPE_TRACE_EN
        test_trace();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
